// File: rtl/gcd_client.sv
// gcd_client: requester-side controller for a GCD engine.
//
// Takes one operand pair at a time from an upstream valid/ready source and
// sends the engine a one-cycle start pulse. It then waits for the engine's
// done strobe. If done does not arrive within TIMEOUT cycles, it returns an
// error response instead. The result goes downstream on a valid/ready output.
// When either operand is zero, the block produces the result itself and does
// not start the engine.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   in_valid/in_ready         upstream handshake; in_a, in_b are the operands
//   gcd_start                 one-cycle request pulse to the engine
//   gcd_a, gcd_b              operands to the engine, held until the next accept
//   gcd_done, gcd_res         engine completion strobe and result
//   out_valid/out_ready       downstream handshake; out_res result, out_err timeout
//   op_count                  count of completed output handshakes (wraps)
module gcd_client #(
  parameter int W       = 4,
  parameter int TIMEOUT = 32,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          gcd_start,
  output logic [W-1:0]  gcd_a,
  output logic [W-1:0]  gcd_b,
  input  logic          gcd_done,
  input  logic [W-1:0]  gcd_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_res,
  output logic          out_err,
  output logic [CW-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // in_ready_q is part of the accept condition, so nothing is taken
        // in the first cycle after reset release, while in_ready is still 0.
        if (in_valid && in_ready_q) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == {W{1'b0}}) || (in_b == {W{1'b0}})) begin
            // gcd(0,x) = x and gcd(0,0) = 0, which is the same as OR-ing the operands.
            res_d   = in_a | in_b;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        timer_d = {TW{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // done is checked first, so a done on the final timeout cycle still counts.
        if (gcd_done) begin
          res_d   = gcd_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d   = {W{1'b0}};
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The handshake/strobe outputs are decoded from the next state so that,
    // once registered, they line up with the state they belong to.
    in_ready_d = (state_d == IDLE);
    start_d    = (state_d == ISSUE);
    valid_d    = (state_d == RESP);
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_q        <= {W{1'b0}};
      b_q        <= {W{1'b0}};
      res_q      <= {W{1'b0}};
      err_q      <= 1'b0;
      timer_q    <= {TW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign gcd_start = start_q;
  assign gcd_a     = a_q;
  assign gcd_b     = b_q;
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_err   = err_q;
  assign op_count  = cnt_q;

endmodule
